calc_engine: RTL and testbench

CALC_ENGINE -- requirements
Module: calc_engine

---
 rtl/calc_engine.sv | 135 +++++++++++++
 tb/tb_calc_engine.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/calc_engine.sv
// Four-cycle register-file ALU engine: accept a command in IDLE, read operands,
// execute, then write back and strobe the result.
module calc_engine #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_wa,
  input  logic [AW-1:0]    cmd_ra,
  input  logic [AW-1:0]    cmd_rb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_flags
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_CLR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]        regs [NREGS];
  logic [2:0]              op_p0;
  logic [AW-1:0]           wa_p0, ra_p0, rb_p0;
  logic [WIDTH-1:0]        imm_p0;
  logic signed [WIDTH-1:0] a_p1, b_p1;
  logic [WIDTH-1:0]        res_p2;
  logic [2:0]              flg_p2;
  logic                    acc;

  // Result packed as {V, C, Z, data}; C and V only meaningful for ADD/SUB.
  function automatic logic [WIDTH+2:0] alu(input logic [2:0] op,
                                           input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b,
                                           input logic [WIDTH-1:0] imm);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c, v;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_LOAD: r = imm;
      OP_CLR:  r = '0;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        r   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      default: r = a;
    endcase
    return {v, c, (r == '0), r};
  endfunction

  assign cmd_ready = (state == IDLE) && !rst;
  assign acc       = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: command capture at the handshake edge
  always_ff @(posedge clk) begin
    if (acc) begin
      op_p0  <= cmd_op;
      wa_p0  <= cmd_wa;
      ra_p0  <= cmd_ra;
      rb_p0  <= cmd_rb;
      imm_p0 <= cmd_imm;
    end
  end

  // p1: operand read
  always_ff @(posedge clk) begin
    if (state == READ) begin
      a_p1 <= regs[ra_p0];
      b_p1 <= regs[rb_p0];
    end
  end

  // p2: execute
  always_ff @(posedge clk) begin
    if (state == EXEC) {flg_p2, res_p2} <= alu(op_p0, a_p1, b_p1, imm_p0);
  end

  // Write-back; reset clears architectural state and aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state     <= state_nxt;
      res_valid <= (state == WB);
      if (state == WB) begin
        res_data  <= res_p2;
        res_flags <= flg_p2;
        if (op_p0 != 3'b111) regs[wa_p0] <= res_p2;
      end
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// Directed bench for calc_engine: hand-computed vectors checked with immediate assertions.
module tb_calc_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b0;
  logic [2:0] cmd_wa = 3'b0, cmd_ra = 3'b0, cmd_rb = 3'b0;
  logic [7:0] cmd_imm = 8'h0;
  logic       res_valid;
  logic [7:0] res_data;
  logic [2:0] res_flags;

  int checks = 0;
  int errors = 0;

  calc_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wa(cmd_wa), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm(cmd_imm), .res_valid(res_valid), .res_data(res_data),
    .res_flags(res_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then check latency, result and hold behaviour.
  task automatic run(input string tag, input logic [2:0] op, input logic [2:0] wa,
                     input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] imm,
                     input logic [7:0] exp_d, input logic [2:0] exp_f);
    int n;
    cmd_op = op; cmd_wa = wa; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    cmd_op = 3'b010; cmd_wa = ~wa; cmd_ra = ~ra; cmd_rb = ~rb; cmd_imm = 8'hA5;
    chk({tag, "_busy"}, {res_valid, cmd_ready}, 2'b00);
    tick();
    chk({tag, "_lat2"}, res_valid, 1'b0);
    tick();
    chk({tag, "_lat3"}, res_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_data"}, res_data, exp_d);
    chk({tag, "_flags"}, res_flags, exp_f);
    tick();
    chk({tag, "_strobe"}, res_valid, 1'b0);
    chk({tag, "_hold"}, {res_flags, res_data}, {exp_f, exp_d});
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_out", {cmd_ready, res_valid, res_flags, res_data}, 13'h0);
    rst = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1'b1);

    // Load, overflow add, borrow subtract
    run("ld_r1", 3'b000, 3'd1, 3'd0, 3'd0, 8'h7F, 8'h7F, 3'b000);
    run("ld_r2", 3'b000, 3'd2, 3'd0, 3'd0, 8'h01, 8'h01, 3'b000);
    run("add_v", 3'b010, 3'd3, 3'd1, 3'd2, 8'h00, 8'h80, 3'b100);
    run("sub_c", 3'b011, 3'd4, 3'd2, 3'd1, 8'h00, 8'h82, 3'b010);
    run("ld_r7", 3'b000, 3'd7, 3'd0, 3'd0, 8'hFF, 8'hFF, 3'b000);
    run("add_cz", 3'b010, 3'd0, 3'd7, 3'd2, 8'h00, 8'h00, 3'b011);
    run("sub_v", 3'b011, 3'd4, 3'd3, 3'd2, 8'h00, 8'h7F, 3'b100);

    // Logic ops; OUT must not write its wa
    run("xor_z", 3'b101, 3'd5, 3'd1, 3'd1, 8'h00, 8'h00, 3'b001);
    run("out_r5", 3'b111, 3'd3, 3'd5, 3'd0, 8'h00, 8'h00, 3'b001);
    run("out_r3", 3'b111, 3'd0, 3'd3, 3'd0, 8'h00, 8'h80, 3'b000);
    run("and", 3'b100, 3'd6, 3'd7, 3'd1, 8'h00, 8'h7F, 3'b000);
    run("or", 3'b110, 3'd6, 3'd1, 3'd3, 8'h00, 8'hFF, 3'b000);
    run("clr", 3'b001, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 3'b001);
    run("out_r7", 3'b111, 3'd0, 3'd7, 3'd0, 8'h00, 8'h00, 3'b001);

    // cmd_valid held high across three queued commands
    begin
      logic [2:0] q_op [3] = '{3'b000, 3'b010, 3'b011};
      logic [2:0] q_wa [3] = '{3'd1, 3'd2, 3'd3};
      logic [2:0] q_ra [3] = '{3'd0, 3'd1, 3'd2};
      logic [2:0] q_rb [3] = '{3'd0, 3'd1, 3'd1};
      logic [7:0] q_im [3] = '{8'h10, 8'h00, 8'h00};
      logic [7:0] q_d  [3] = '{8'h10, 8'h20, 8'h10};
      cmd_op = q_op[0]; cmd_wa = q_wa[0]; cmd_ra = q_ra[0]; cmd_rb = q_rb[0]; cmd_imm = q_im[0];
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk("bb_ready", cmd_ready, 1'b1);
        tick();
        if (i < 2) begin
          cmd_op = q_op[i+1]; cmd_wa = q_wa[i+1]; cmd_ra = q_ra[i+1];
          cmd_rb = q_rb[i+1]; cmd_imm = q_im[i+1];
        end else begin
          cmd_valid = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
          chk("bb_busy", {cmd_ready, res_valid}, 2'b00);
          tick();
        end
        chk("bb_valid", res_valid, 1'b1);
        chk("bb_data", {res_flags, res_data}, {3'b000, q_d[i]});
      end
      tick();
      chk("bb_end", res_valid, 1'b0);
    end

    // Self-referencing add
    run("ld_40", 3'b000, 3'd1, 3'd0, 3'd0, 8'h40, 8'h40, 3'b000);
    run("add_self", 3'b010, 3'd1, 3'd1, 3'd1, 8'h00, 8'h80, 3'b100);
    run("out_r1", 3'b111, 3'd0, 3'd1, 3'd0, 8'h00, 8'h80, 3'b000);

    // Reset pulsed during EXEC aborts the command and clears the file
    run("ld_r2b", 3'b000, 3'd2, 3'd0, 3'd0, 8'h05, 8'h05, 3'b000);
    cmd_op = 3'b010; cmd_wa = 3'd6; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_valid = 1'b1;
    chk("ab_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("ab_rst_out", {cmd_ready, res_valid, res_flags, res_data}, 13'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("ab_ready2", cmd_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("ab_novalid", res_valid, 1'b0);
      tick();
    end
    run("ab_out_r6", 3'b111, 3'd0, 3'd6, 3'd0, 8'h00, 8'h00, 3'b001);
    run("ab_out_r1", 3'b111, 3'd0, 3'd1, 3'd0, 8'h00, 8'h00, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
